// File: rtl/immgen_stage.sv
// immgen_stage: ID-stage immediate generator with an elastic valid/ready output buffer.
//   Parameters: XLEN (32|64) output width, SKID (1 = 2-entry skid buffer with
//   registered in_ready, 0 = single pipeline register), TAG_W sideband width.
//   Ports: clk, rst_n (async active-low), flush (sync kill of buffered entries),
//   in_valid/in_ready/instr[31:7]/sel/tag on the input side,
//   out_valid/out_ready/out_imm/out_err/out_tag on the output side.
module immgen_stage #(
  parameter int XLEN  = 32,
  parameter int SKID  = 1,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [24:0]      instr,
  input  logic [2:0]       sel,
  input  logic [TAG_W-1:0] tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_err,
  output logic [TAG_W-1:0] out_tag
);
  localparam int EW = XLEN + TAG_W + 1;
  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("immgen_stage: XLEN must be 32 or 64");
  end
  // instr port bit i carries instruction bit i+7, so instruction bit k is instr[k-7]
  logic            s;
  logic [XLEN-1:0] imm_d;
  logic [EW-1:0]   ent_d;
  logic [EW-1:0]   head_q;
  logic            push;
  logic            pop;
  assign s = instr[24];
  always_comb
    imm_d = sel == 3'd0 ? {{(XLEN-12){s}}, instr[24:13]} :
            sel == 3'd1 ? {{(XLEN-12){s}}, instr[24:18], instr[4:0]} :
            sel == 3'd2 ? {{(XLEN-12){s}}, instr[0], instr[23:18], instr[4:1], 1'b0} :
            sel == 3'd3 ? {{(XLEN-20){s}}, instr[12:5], instr[13], instr[23:14], 1'b0} :
            sel == 3'd4 ? {{(XLEN-31){s}}, instr[23:5], 12'b0} :
            sel == 3'd5 ? {{(XLEN-5){1'b0}}, instr[12:8]} :
            sel == 3'd6 ? (XLEN == 64 ? {{(XLEN-6){1'b0}}, instr[18:13]}
                                      : {{(XLEN-5){1'b0}}, instr[17:13]}) :
            '0;
  assign ent_d = {sel == 3'd7, tag, imm_d};
  assign {out_err, out_tag, out_imm} = head_q;
  // in_ready already carries ~flush, so a flushed cycle never pushes
  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;
  if (SKID != 0) begin : g_skid
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
    state_t        st_q;
    logic [EW-1:0] skid_q;
    logic          rdy_q;
    logic          vld_q;
    assign in_ready  = rdy_q & ~flush;
    assign out_valid = vld_q;
    // head_q is always the presented entry; skid_q holds the one that arrived while the head stalled
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        st_q   <= EMPTY;
        head_q <= '0;
        skid_q <= '0;
        rdy_q  <= 1'b1;
        vld_q  <= 1'b0;
      end else if (flush) begin
        st_q  <= EMPTY;
        rdy_q <= 1'b1;
        vld_q <= 1'b0;
      end else begin
        case (st_q)
          EMPTY: if (push) begin
            head_q <= ent_d;
            st_q   <= ONE;
            vld_q  <= 1'b1;
          end
          ONE: if (push && pop) head_q <= ent_d;
          else if (push) begin
            skid_q <= ent_d;
            st_q   <= TWO;
            rdy_q  <= 1'b0;
          end else if (pop) begin
            st_q  <= EMPTY;
            vld_q <= 1'b0;
          end
          TWO: if (pop) begin
            head_q <= skid_q;
            st_q   <= ONE;
            rdy_q  <= 1'b1;
          end
          default: st_q <= EMPTY;
        endcase
      end
  end else begin : g_reg
    logic vld_q;
    assign in_ready  = (~vld_q | out_ready) & ~flush;
    assign out_valid = vld_q;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        vld_q  <= 1'b0;
        head_q <= '0;
      end else if (flush) vld_q <= 1'b0;
      else if (push) begin
        head_q <= ent_d;
        vld_q  <= 1'b1;
      end else if (pop) vld_q <= 1'b0;
  end
endmodule

// File: tb/tb_immgen_stage.sv
// tb_immgen_stage: scoreboard bench for immgen_stage (XLEN=32/SKID=0 and XLEN=64/SKID=1)
module tb_immgen_stage;
  typedef struct {
    logic [63:0] imm;
    logic        err;
    logic [4:0]  tag;
  } exp_t;
  logic        clk;
  logic        rst_n;
  logic [1:0]  fl, iv, ir, ov, ordy, oerr;
  logic [24:0] ins [2];
  logic [2:0]  sl [2];
  logic [4:0]  tg [2];
  logic [4:0]  otg [2];
  logic [63:0] oim [2];
  logic [31:0] oim32;
  int tests = 0;
  int fails = 0;
  assign oim[0] = {32'b0, oim32};
  immgen_stage #(.XLEN(32), .SKID(0), .TAG_W(5)) u0 (
    .clk(clk), .rst_n(rst_n), .flush(fl[0]), .in_valid(iv[0]), .in_ready(ir[0]),
    .instr(ins[0]), .sel(sl[0]), .tag(tg[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
    .out_imm(oim32), .out_err(oerr[0]), .out_tag(otg[0]));
  immgen_stage #(.XLEN(64), .SKID(1), .TAG_W(5)) u1 (
    .clk(clk), .rst_n(rst_n), .flush(fl[1]), .in_valid(iv[1]), .in_ready(ir[1]),
    .instr(ins[1]), .sel(sl[1]), .tag(tg[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
    .out_imm(oim[1]), .out_err(oerr[1]), .out_tag(otg[1]));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  // Reference: rebuild the 32-bit instruction word and extract fields arithmetically
  function automatic logic [64:0] ref_imm(input int xl, input logic [24:0] p, input logic [2:0] s);
    logic [31:7] w;
    longint      sw;
    logic [63:0] r;
    w  = p;
    sw = longint'(signed'({w, 7'b0}));
    case (s)
      3'd0: r = sw >>> 20;
      3'd1: r = ((sw >>> 25) <<< 5) | longint'(w[11:7]);
      3'd2: r = ((sw >>> 31) <<< 12) | (longint'(w[7]) << 11) | (longint'(w[30:25]) << 5) | (longint'(w[11:8]) << 1);
      3'd3: r = ((sw >>> 31) <<< 20) | (longint'(w[19:12]) << 12) | (longint'(w[20]) << 11) | (longint'(w[30:21]) << 1);
      3'd4: r = (sw >>> 12) <<< 12;
      3'd5: r = longint'(w[19:15]);
      3'd6: r = xl == 64 ? longint'(w[25:20]) : longint'(w[24:20]);
      default: r = 64'd0;
    endcase
    if (xl == 32) r[63:32] = 32'd0;
    return {s == 3'd7, r};
  endfunction
  for (genvar g = 0; g < 2; g++) begin : g_mon
    exp_t        q[$];
    exp_t        e;
    logic        hv;
    logic [63:0] pim;
    logic        perr;
    logic [4:0]  ptag;
    logic        exp_ir;
    logic [64:0] r;
    always @(negedge clk) begin
      if (!rst_n) begin
        q.delete();
        hv = 1'b0;
      end else begin
        exp_ir = fl[g] ? 1'b0 : g == 1 ? q.size() < 2 : (q.size() == 0 || ordy[g]);
        chk($sformatf("out_valid[%0d]", g), 64'(ov[g]), 64'(q.size() != 0));
        chk($sformatf("in_ready[%0d]", g), 64'(ir[g]), 64'(exp_ir));
        if (hv) begin
          chk($sformatf("hold_imm[%0d]", g), oim[g], pim);
          chk($sformatf("hold_err[%0d]", g), 64'(oerr[g]), 64'(perr));
          chk($sformatf("hold_tag[%0d]", g), 64'(otg[g]), 64'(ptag));
        end
        hv   = ov[g] & ~ordy[g] & ~fl[g];
        pim  = oim[g];
        perr = oerr[g];
        ptag = otg[g];
        if (fl[g]) q.delete();
        else begin
          if (ov[g] && ordy[g] && q.size() != 0) begin
            e = q.pop_front();
            chk($sformatf("imm[%0d]", g), oim[g], e.imm);
            chk($sformatf("err[%0d]", g), 64'(oerr[g]), 64'(e.err));
            chk($sformatf("tag[%0d]", g), 64'(otg[g]), 64'(e.tag));
          end
          if (iv[g] && ir[g]) begin
            r = ref_imm(g == 1 ? 64 : 32, ins[g], sl[g]);
            q.push_back('{r[63:0], r[64], tg[g]});
          end
        end
      end
    end
  end
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input int d, input logic v, input logic [24:0] i, input logic [2:0] s, input logic [4:0] t);
    iv[d]  = v;
    ins[d] = i;
    sl[d]  = s;
    tg[d]  = t;
  endtask
  task automatic dir(input int d, input logic [24:0] i, input logic [2:0] s,
                     input logic [63:0] ei, input logic ee, input string nm);
    drive(d, 1'b1, i, s, 5'd3);
    ordy[d] = 1'b1;
    step;
    iv[d] = 1'b0;
    @(negedge clk);
    chk({nm, "_valid"}, 64'(ov[d]), 64'd1);
    chk({nm, "_imm"}, oim[d], ei);
    chk({nm, "_err"}, 64'(oerr[d]), 64'(ee));
  endtask
  task automatic rnd(input int d);
    drive(d, $urandom_range(0, 9) < 7, 25'($urandom), 3'($urandom), 5'($urandom));
    ordy[d] = $urandom_range(0, 9) < 6;
    fl[d]   = $urandom_range(0, 63) == 0;
  endtask
  task automatic chk_zero(input string nm);
    for (int d = 0; d < 2; d++) begin
      chk({nm, "_ov"}, 64'(ov[d]), 64'd0);
      chk({nm, "_imm"}, oim[d], 64'd0);
      chk({nm, "_err"}, 64'(oerr[d]), 64'd0);
      chk({nm, "_tag"}, 64'(otg[d]), 64'd0);
    end
  endtask
  initial begin
    rst_n = 1'b0;
    fl = '0;
    ordy = '0;
    for (int d = 0; d < 2; d++) drive(d, 1'b0, '0, '0, '0);
    #12;
    chk_zero("reset");
    #1 rst_n = 1'b1;
    step;
    chk("rst_in_ready0", 64'(ir[0]), 64'd1);
    chk("rst_in_ready1", 64'(ir[1]), 64'd1);
    dir(0, {12'hFFF, 13'd0}, 3'd0, 64'h0000_0000_FFFF_FFFF, 1'b0, "i32");
    dir(0, 25'h100_0000 | (25'h3F << 13), 3'd6, 64'd31, 1'b0, "sh32");
    dir(1, 25'h1FF_FFFF, 3'd3, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, "uj64");
    dir(1, 25'h100_0000 | (25'h3F << 13), 3'd6, 64'd63, 1'b0, "sh64");
    dir(1, 25'h100_0000 | (25'h1F << 8), 3'd5, 64'd31, 1'b0, "z64");
    dir(1, 25'h1FF_FFFF, 3'd7, 64'd0, 1'b1, "rsv64");
    step;
    ordy[1] = 1'b0;
    drive(1, 1'b1, {12'h005, 13'd0}, 3'd0, 5'd1);
    step;
    drive(1, 1'b1, {12'h7FF, 13'd0}, 3'd0, 5'd2);
    step;
    iv[1] = 1'b0;
    @(negedge clk);
    chk("two_in_ready", 64'(ir[1]), 64'd0);
    chk("two_hold_a", oim[1], 64'd5);
    step;
    ordy[1] = 1'b1;
    @(negedge clk);
    chk("pop_a", oim[1], 64'd5);
    step;
    @(negedge clk);
    chk("pop_b", oim[1], 64'd2047);
    chk("pop_b_in_ready", 64'(ir[1]), 64'd1);
    step;
    ordy[1] = 1'b0;
    drive(1, 1'b1, {12'h011, 13'd0}, 3'd0, 5'd4);
    step;
    drive(1, 1'b1, {12'h022, 13'd0}, 3'd0, 5'd5);
    step;
    iv[1]   = 1'b0;
    fl[1]   = 1'b1;
    ordy[1] = 1'b1;
    step;
    fl[1] = 1'b0;
    @(negedge clk);
    chk("flush_ov", 64'(ov[1]), 64'd0);
    chk("flush_in_ready", 64'(ir[1]), 64'd1);
    fork
      for (int c = 0; c < 8000; c++) begin
        step;
        rnd(0);
      end
      for (int c = 0; c < 8000; c++) begin
        step;
        rnd(1);
      end
      begin
        repeat (4000) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk_zero("async_rst");
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
      end
    join
    step;
    fl = '0;
    ordy = 2'b11;
    iv = '0;
    repeat (10) step;
    @(negedge clk);
    chk("drain_ov0", 64'(ov[0]), 64'd0);
    chk("drain_ov1", 64'(ov[1]), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
